// File: rtl/sub_shift_rows.sv
// AES SubBytes + ShiftRows on a 128-bit column-major state, one column per cycle
// through four S-box lookups, handing the result to mixColumns over a valid/ready pair.

module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // FIPS-197 S-box, row 0 first; stored descending so entry x sits at index ~x
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[~a_i];
endmodule

module sub_shift_rows (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q;
  logic [1:0]     col_q;
  logic [127:0]   din_q;
  logic           last_q;
  logic [127:0]   dout_q, dout_d;
  logic           out_last_q;
  logic [3:0][7:0] sb_in, sb_out;

  genvar r, c;
  generate
    for (r = 0; r < 4; r++) begin : g_row
      // row r of the captured column selected by col_q
      assign sb_in[r] = (col_q == 2'd0) ? din_q[127-8*r      -: 8] :
                        (col_q == 2'd1) ? din_q[127-8*(4+r)  -: 8] :
                        (col_q == 2'd2) ? din_q[127-8*(8+r)  -: 8] :
                                          din_q[127-8*(12+r) -: 8];
      sbox u_sbox (.a_i(sb_in[r]), .s_o(sb_out[r]));

      for (c = 0; c < 4; c++) begin : g_col
        // out(r,c) takes the substituted byte when col_q == (c + r) mod 4
        localparam logic [1:0] SRC = 2'((c + r) % 4);
        assign dout_d[127-8*(4*c+r) -: 8] =
          (state_q == SUB && col_q == SRC) ? sb_out[r] : dout_q[127-8*(4*c+r) -: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= 2'd0;
      din_q      <= '0;
      last_q     <= 1'b0;
      dout_q     <= '0;
      out_last_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      case (state_q)
        IDLE: if (in_valid) begin
          din_q   <= in_data;
          last_q  <= in_last;
          col_q   <= 2'd0;
          state_q <= SUB;
        end
        SUB: begin
          col_q      <= col_q + 2'd1;
          out_last_q <= last_q;
          if (col_q == 2'd3) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = dout_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_sub_shift_rows.sv
// Directed + random checks of sub_shift_rows against an S-box computed from GF(2^8) math.

module tb_sub_shift_rows;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb [256];

  sub_shift_rows dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // inverse as x^254, then the affine map
  function automatic logic [7:0] sbox_math(logic [7:0] x);
    logic [7:0] p = 8'h01;
    for (int i = 0; i < 254; i++) p = gmul(p, x);
    return p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] get_byte(logic [127:0] d, int b);
    return 8'(d >> (8 * (15 - b)));
  endfunction

  // out(r,c) = S(in(r,(c+r) mod 4)), byte index b = 4*col + row
  function automatic logic [127:0] ref_blk(logic [127:0] d);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o = o | (128'(sb[get_byte(d, 4 * ((c + r) % 4) + r)]) << (8 * (15 - (4 * c + r))));
    return o;
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // handshake one block and check latency, data and last; out_ready held high
  task automatic run_block(logic [127:0] d, logic l, logic [127:0] exp);
    in_data = d; in_last = l; in_valid = 1'b1; out_ready = 1'b1;
    chk("hs_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lat_vld_e%0d", i), 128'(out_valid), 128'(i == 4));
    end
    chk("blk_data", out_data, exp);
    chk("blk_data_ref", out_data, ref_blk(d));
    chk("blk_last", 128'(out_last), 128'(l));
    tick();
    chk("blk_idle_vld", 128'(out_valid), 128'(0));
    chk("blk_idle_rdy", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] held, a, b, d;
    int hs[$];
    logic [127:0] outs[$];
    logic [128:0] expq[$];
    int cyc, got_n;
    logic l, hs_b;

    for (int x = 0; x < 256; x++) sb[x] = sbox_math(8'(x));

    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    rst = 1'b0;

    // FIPS-197 App. B round 1 and the all-zero block
    run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    run_block(128'h0, 1'b1, {16{8'h63}});

    // backpressure with input noise
    d = {$urandom, $urandom, $urandom, $urandom};
    in_data = d; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_vld", 128'(out_valid), 128'(1));
    held = out_data;
    chk("bp_data", held, ref_blk(d));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2); in_data = {$urandom, $urandom, $urandom, $urandom}; in_last = 1'b1;
      tick();
      chk("bp_hold_vld", 128'(out_valid), 128'(1));
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_last", 128'(out_last), 128'(0));
      chk("bp_hold_rdy", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_vld", 128'(out_valid), 128'(0));
    chk("bp_release_rdy", 128'(in_ready), 128'(1));

    // back-to-back with in_valid/out_ready high
    a = 128'h00112233445566778899aabbccddeeff;
    b = 128'h3243f6a8885a308d313198a2e0370734;
    in_data = a; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 13; cyc++) begin
      hs_b = in_valid && in_ready;
      if (hs_b) hs.push_back(cyc);
      if (out_valid && out_ready) outs.push_back(out_data);
      tick();
      if (hs_b) begin
        in_data = b;
        if (hs.size() == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_hs_count", 128'(hs.size()), 128'(2));
    if (hs.size() == 2) chk("b2b_spacing", 128'(hs[1] - hs[0]), 128'(6));
    chk("b2b_out_count", 128'(outs.size()), 128'(2));
    if (outs.size() == 2) begin
      chk("b2b_out0", outs[0], ref_blk(a));
      chk("b2b_out1", outs[1], ref_blk(b));
    end

    // reset in SUB with col=2
    d = {$urandom, $urandom, $urandom, $urandom};
    in_data = d; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 128'(out_valid), 128'(0));
    chk("mid_rst_data", out_data, 128'(0));
    chk("mid_rst_rdy", 128'(in_ready), 128'(1));
    chk("mid_rst_last", 128'(out_last), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_out", 128'(out_valid), 128'(0));
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block(d, 1'b0, ref_blk(d));

    // random traffic against a queue of expected results
    got_n = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (got_n < 1000) begin
      if (in_valid && in_ready && hs.size() < 1002) begin
        expq.push_back({in_last, ref_blk(in_data)});
        hs.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("rnd_dup", 128'(1), 128'(0));
        else begin
          {l, d} = expq.pop_front();
          chk($sformatf("rnd_data_%0d", got_n), out_data, d);
          chk($sformatf("rnd_last_%0d", got_n), 128'(out_last), 128'(l));
        end
        got_n++;
      end
      tick();
      cyc++;
      if (cyc > 40000) begin
        chk("rnd_timeout", 128'(got_n), 128'(1000));
        break;
      end
      in_valid  = ($urandom_range(0, 1) == 1) && (hs.size() < 1002);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_last   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid = 1'b0;
    chk("rnd_no_leftover", 128'(expq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
